pending_encoder: RTL

Sequential counterpart to the one-hot decoder: collects request bits from an OUT-wide one-hot/multi-hot request bus, holds them as pending, and emits them one at a time as binary indices over a valid/ready handshake. Lowest index has fixed priority. Sits between event sources that raise per-line request bits and any consumer that wants a serialized stream of line numbers, such as a decoder driving a per-line acknowledge.

---
 rtl/pending_encoder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pending_encoder.sv
// rtl/pending_encoder.sv - pending-request collector that serializes line numbers over valid/ready
module pending_encoder #(
    parameter int N_IN = 3,
    parameter int OUT  = 2**N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OUT-1:0]  req,
    input  logic            ready,
    output logic [N_IN-1:0] N,
    output logic            valid,
    output logic [OUT-1:0]  pending,
    output logic [N_IN:0]   count,
    output logic            overflow
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } stage_t;

    stage_t          r_state;
    stage_t          w_state_next;
    logic [OUT-1:0]  r_pend;
    logic [N_IN-1:0] r_n;
    logic [N_IN:0]   r_count;
    logic            r_overflow;

    logic            w_free;
    logic            w_load;
    logic [N_IN-1:0] w_idx;
    logic [OUT-1:0]  w_load_mask;
    logic [OUT-1:0]  w_pend_next;
    logic [OUT-1:0]  w_dup;
    logic [N_IN:0]   w_count_next;

    function automatic logic [N_IN:0] popcount(input logic [OUT-1:0] v);
        logic [N_IN:0] c;
        c = '0;
        for (int k = 0; k < OUT; k++) begin
            c = c + {{N_IN{1'b0}}, v[k]};
        end
        return c;
    endfunction

    // The stage can take a new index when empty or when the held one is being accepted.
    assign w_free = (r_state == S_EMPTY) || ready;
    assign w_load = w_free && (|r_pend);

    // Lowest set index of the registered pend vector; req is deliberately not looked at.
    always_comb begin
        w_idx = '0;
        for (int k = OUT - 1; k >= 0; k--) begin
            if (r_pend[k]) begin
                w_idx = N_IN'(k);
            end
        end
    end

    // One-hot of the line leaving pend this edge, then merge in new requests.
    always_comb begin
        w_load_mask = '0;
        if (w_load) begin
            w_load_mask[w_idx] = 1'b1;
        end
        w_pend_next  = (r_pend & ~w_load_mask) | req;
        w_dup        = req & r_pend & ~w_load_mask;
        w_count_next = popcount(w_pend_next);
    end

    // Output stage next state: refill when free and something is pending, else drain.
    always_comb begin
        w_state_next = r_state;
        if (w_free) begin
            w_state_next = (|r_pend) ? S_HOLD : S_EMPTY;
        end
    end

    // Output stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Presented index; keeps its last value when the stage drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n <= '0;
        end else if (w_load) begin
            r_n <= w_idx;
        end
    end

    // Pending vector and its population count, updated together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_count <= '0;
        end else begin
            r_pend  <= w_pend_next;
            r_count <= w_count_next;
        end
    end

    // Sticky drop flag: a request hit a line that was already pending and not leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (|w_dup) begin
            r_overflow <= 1'b1;
        end
    end

    assign N        = r_n;
    assign valid    = (r_state == S_HOLD);
    assign pending  = r_pend;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
